// File: rtl/eth_cmd_pkg.sv
// Shared constants for the Ethernet command receiver: ethertypes, IPv4/UDP/ARP
// constants, byte offsets within a frame (offset 0 = destination MAC byte 0),
// FSM state encoding and a one's-complement add helper.
package eth_cmd_pkg;

  localparam logic [15:0] EthTypeIpv4  = 16'h0800;
  localparam logic [15:0] EthTypeArp   = 16'h0806;
  localparam logic [15:0] ArpOpRequest = 16'h0001;
  localparam logic [7:0]  IpVerIhl     = 8'h45;
  localparam logic [7:0]  IpProtoUdp   = 8'd17;

  localparam int unsigned OffEthType   = 12;
  localparam int unsigned OffIpVer     = 14;
  localparam int unsigned OffIpProto   = 23;
  localparam int unsigned OffIpDst     = 30;
  localparam int unsigned OffUdpDst    = 36;
  localparam int unsigned OffCmd       = 42;
  localparam int unsigned OffCmdChk    = 43;
  localparam int unsigned OffParam     = 44;
  localparam int unsigned OffArpOper   = 20;
  localparam int unsigned OffArpSha    = 22;
  localparam int unsigned OffArpSpa    = 28;
  localparam int unsigned OffArpTpa    = 38;
  localparam int unsigned OffCsumFirst = 14;
  localparam int unsigned OffCsumLast  = 33;
  localparam int unsigned MinFrameLen  = 14;
  localparam int unsigned ArpMinLen    = 42;

  localparam logic [10:0] IdxMax = 11'h7FF;

  typedef enum logic [1:0] {StSync, StIdle, StRx, StEval} state_e;

  // 16-bit one's-complement add with end-around carry.
  function automatic logic [15:0] csum_add(logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/eth_ip_csum.sv
// One's-complement accumulator over big-endian byte pairs (IPv4 header checksum).
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clear_i       restart the sum (first byte of a frame)
//   valid_i       data_i is a header byte to accumulate
//   hi_i          data_i is the high (first) byte of a 16-bit word
//   data_i        byte
//   sum_o         running folded sum
module eth_ip_csum
  import eth_cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic        hi_i,
  input  logic [7:0]  data_i,
  output logic [15:0] sum_o
);

  logic [7:0]  hi_q, hi_d;
  logic [15:0] sum_q, sum_d;

  always_comb begin
    hi_d  = hi_q;
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 16'h0000;
    end else if (valid_i) begin
      if (hi_i) hi_d = data_i;
      else      sum_d = csum_add(sum_q, {hi_q, data_i});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= 8'h00;
      sum_q <= 16'h0000;
    end else begin
      hi_q  <= hi_d;
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/eth_cmd_rx.sv
// Ethernet command receiver: captures UDP command frames and ARP requests
// addressed to this station from a byte stream (no preamble).
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rxdv, i_rxd             byte stream; a frame is a contiguous i_rxdv high run
//   i_local_mac, i_local_ip   station addresses, sampled when the frame is evaluated
//   o_cmd_come, o_cmd, o_param   command pulse, command byte, big-endian parameter
//   o_arp_req, o_arp_smac, o_arp_sip  ARP request pulse, requester MAC/IP
//   o_drop_cnt                saturating count of rejected frames
// Build option: define ETH_CMD_IPCHK_EN to require a valid IPv4 header checksum.
module eth_cmd_rx
  import eth_cmd_pkg::*;
#(
  parameter int unsigned PARAM_BYTES = 4,
  parameter logic [15:0] UDP_PORT    = 16'hFEEF,
  parameter bit          CMD_CHK     = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rxdv,
  input  logic [7:0]               i_rxd,
  input  logic [47:0]              i_local_mac,
  input  logic [31:0]              i_local_ip,
  output logic                     o_cmd_come,
  output logic [7:0]               o_cmd,
  output logic [8*PARAM_BYTES-1:0] o_param,
  output logic                     o_arp_req,
  output logic [47:0]              o_arp_smac,
  output logic [31:0]              o_arp_sip,
  output logic [15:0]              o_drop_cnt
);

  localparam int unsigned BufBytes = OffParam + PARAM_BYTES;

  state_e      state_q, state_d;
  logic [10:0] idx_q, idx_d, wr_idx;
  logic        cap, eval;
  logic [7:0]  hdr_q [BufBytes];

  // idx_q counts bytes of the current frame; in EVAL it is the frame length.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    eval    = 1'b0;
    unique case (state_q)
      StSync: if (!i_rxdv) state_d = StIdle;
      StIdle: if (i_rxdv) begin
        cap     = 1'b1;
        state_d = StRx;
      end
      StRx: begin
        if (i_rxdv) cap = 1'b1;
        else        state_d = StEval;
      end
      StEval: begin
        eval = 1'b1;
        // A new frame may begin here; its first byte goes to index 0.
        if (i_rxdv) begin
          cap     = 1'b1;
          state_d = StRx;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StSync;
    endcase
    wr_idx = (state_q == StRx) ? idx_q : 11'd0;
    idx_d  = idx_q;
    if (cap) idx_d = (wr_idx == IdxMax) ? IdxMax : wr_idx + 11'd1;
  end

  always_ff @(posedge i_clk) begin
    if (cap && (wr_idx < 11'(BufBytes))) hdr_q[wr_idx[5:0]] <= i_rxd;
  end

  logic [47:0]              dmac;
  logic [8*PARAM_BYTES-1:0] param_w;
  logic [BufBytes-1:0]      unused_hdr;
  logic                     csum_ok, too_long, cmd_ok, arp_ok;

  assign dmac = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};

  for (genvar g = 0; g < PARAM_BYTES; g++) begin : g_param
    assign param_w[8*(PARAM_BYTES-1-g) +: 8] = hdr_q[OffParam+g];
  end

  for (genvar g = 0; g < BufBytes; g++) begin : g_unused
    assign unused_hdr[g] = ^hdr_q[g];
  end

`ifdef ETH_CMD_IPCHK_EN
  logic [15:0] csum;

  eth_ip_csum u_csum (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clear_i (cap && (wr_idx == 11'd0)),
    .valid_i (cap && (wr_idx >= 11'(OffCsumFirst)) && (wr_idx <= 11'(OffCsumLast))),
    .hi_i    (~wr_idx[0]),
    .data_i  (i_rxd),
    .sum_o   (csum)
  );

  assign csum_ok = (csum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  assign too_long = (idx_q == IdxMax);

  assign cmd_ok = !too_long && (idx_q >= 11'(BufBytes)) && (dmac == i_local_mac) &&
                  ({hdr_q[OffEthType], hdr_q[OffEthType+1]} == EthTypeIpv4) &&
                  (hdr_q[OffIpVer] == IpVerIhl) && (hdr_q[OffIpProto] == IpProtoUdp) &&
                  ({hdr_q[OffIpDst], hdr_q[OffIpDst+1], hdr_q[OffIpDst+2],
                    hdr_q[OffIpDst+3]} == i_local_ip) &&
                  ({hdr_q[OffUdpDst], hdr_q[OffUdpDst+1]} == UDP_PORT) &&
                  (!CMD_CHK || (hdr_q[OffCmdChk] == ~hdr_q[OffCmd])) && csum_ok;

  assign arp_ok = !too_long && (idx_q >= 11'(ArpMinLen)) &&
                  ((dmac == i_local_mac) || (dmac == 48'hFFFF_FFFF_FFFF)) &&
                  ({hdr_q[OffEthType], hdr_q[OffEthType+1]} == EthTypeArp) &&
                  ({hdr_q[OffArpOper], hdr_q[OffArpOper+1]} == ArpOpRequest) &&
                  ({hdr_q[OffArpTpa], hdr_q[OffArpTpa+1], hdr_q[OffArpTpa+2],
                    hdr_q[OffArpTpa+3]} == i_local_ip);

  logic                     cmd_come_q, cmd_come_d, arp_req_q, arp_req_d;
  logic [7:0]               cmd_q, cmd_d;
  logic [8*PARAM_BYTES-1:0] param_q, param_d;
  logic [47:0]              smac_q, smac_d;
  logic [31:0]              sip_q, sip_d;
  logic [15:0]              drop_q, drop_d;

  always_comb begin
    cmd_come_d = eval && cmd_ok;
    arp_req_d  = eval && arp_ok;
    cmd_d      = cmd_come_d ? hdr_q[OffCmd] : cmd_q;
    param_d    = cmd_come_d ? param_w : param_q;
    smac_d     = arp_req_d ? {hdr_q[OffArpSha], hdr_q[OffArpSha+1], hdr_q[OffArpSha+2],
                              hdr_q[OffArpSha+3], hdr_q[OffArpSha+4], hdr_q[OffArpSha+5]}
                           : smac_q;
    sip_d      = arp_req_d ? {hdr_q[OffArpSpa], hdr_q[OffArpSpa+1], hdr_q[OffArpSpa+2],
                              hdr_q[OffArpSpa+3]} : sip_q;
    drop_d     = drop_q;
    if (eval && (idx_q >= 11'(MinFrameLen)) && !cmd_ok && !arp_ok && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StSync;
      idx_q      <= 11'd0;
      cmd_come_q <= 1'b0;
      arp_req_q  <= 1'b0;
      cmd_q      <= 8'h00;
      param_q    <= '0;
      smac_q     <= 48'h0;
      sip_q      <= 32'h0;
      drop_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cmd_come_q <= cmd_come_d;
      arp_req_q  <= arp_req_d;
      cmd_q      <= cmd_d;
      param_q    <= param_d;
      smac_q     <= smac_d;
      sip_q      <= sip_d;
      drop_q     <= drop_d;
    end
  end

  assign o_cmd_come = cmd_come_q;
  assign o_cmd      = cmd_q;
  assign o_param    = param_q;
  assign o_arp_req  = arp_req_q;
  assign o_arp_smac = smac_q;
  assign o_arp_sip  = sip_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: doc/eth_cmd_rx.md
ETH_CMD_RX -- requirements
Module: eth_cmd_rx

Interface
REQ-001 Parameter PARAM_BYTES, default 4, command parameter length in bytes (legal 1..8).
REQ-002 Parameter UDP_PORT, default 16'hFEEF, UDP destination port accepted for commands.
REQ-003 Parameter CMD_CHK, default 1, requires payload byte 1 == ~cmd when 1; ignores byte 1 when 0.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_rxdv, i_rxd  in  1, 8  receive byte stream; frame = contiguous i_rxdv high run, first byte = destination MAC byte 0, no preamble.
REQ-007 i_local_mac, i_local_ip  in  48, 32  station addresses, sampled at frame end.
REQ-008 o_cmd_come  out  1  one-cycle pulse, valid command.
REQ-009 o_cmd, o_param  out  8, 8*PARAM_BYTES  command byte; parameter, big-endian; held until next o_cmd_come.
REQ-010 o_arp_req  out  1  one-cycle pulse, ARP request addressed to this station.
REQ-011 o_arp_smac, o_arp_sip  out  48, 32  requester MAC and IP; held until next o_arp_req.
REQ-012 o_drop_cnt  out  16  count of rejected frames.

Function
REQ-013 11-bit byte index, starts at 0 on each frame's first byte, saturates at 2047.
REQ-014 States: SYNC (wait for i_rxdv low), IDLE, RX (capture fields by index), EVAL (one cycle, decide).
REQ-015 IDLE->RX on i_rxdv=1; RX->EVAL on first i_rxdv=0; EVAL->IDLE; SYNC->IDLE on i_rxdv=0.
REQ-016 o_cmd_come/o_arp_req assert in the cycle after EVAL, i.e. 2 cycles after the first i_rxdv=0 sample; exactly one cycle high.
REQ-017 Command accepted when: bytes 0-5 == i_local_mac; bytes 12-13 == 0x0800; byte 14 == 0x45; byte 23 == 17; bytes 30-33 == i_local_ip; bytes 36-37 == UDP_PORT; length >= 44+PARAM_BYTES; CMD_CHK rule holds.
REQ-018 Command fields: o_cmd = byte 42, o_param = bytes 44..43+PARAM_BYTES; trailing bytes ignored.
REQ-019 ARP accepted when: bytes 0-5 == i_local_mac or all-FF; bytes 12-13 == 0x0806; bytes 20-21 == 0x0001; bytes 38-41 == i_local_ip; length >= 42; smac = bytes 22-27, sip = bytes 28-31.
REQ-020 Frame of >= 14 bytes accepted by neither rule increments o_drop_cnt; shorter frames ignored silently.
REQ-021 Frame reaching 2047 bytes is dropped regardless of content.
REQ-022 o_drop_cnt saturates at 16'hFFFF.
REQ-023 Next frame may start in the EVAL cycle (1-cycle gap); capture of it is not disturbed.
REQ-024 Output registers change only on an accepting frame.

Reset
REQ-025 i_rst: all outputs 0, o_drop_cnt 0, state SYNC.
REQ-026 Reset mid-frame: frame discarded, no pulse, no count; remaining bytes ignored until i_rxdv seen low.

Configuration
REQ-027 Macro ETH_CMD_IPCHK_EN defined: IPv4 header (bytes 14-33) one's-complement sum, folded, must equal 16'hFFFF for command acceptance, else drop.
REQ-028 Macro undefined: header checksum not examined; no checksum logic instantiated.

Structure
REQ-029 Package eth_cmd_pkg: ethertypes 0x0800/0x0806, UDP protocol 17, ARP opcode, byte offsets, state encoding.
REQ-030 Sub-module eth_ip_csum: 16-bit one's-complement accumulator over byte pairs, instantiated only under ETH_CMD_IPCHK_EN.

Verification
REQ-031 Mac 02:00:00:00:00:04, IP C0A80104, macro off; UDP frame to FEEF, payload 01 FE C0 A8 01 AA -> o_cmd_come once, o_cmd 01, o_param C0A801AA.
REQ-032 Same frame, byte 33 = AA (other IP) -> no pulse, o_drop_cnt 1; then payload 00 FF -> o_cmd 00 accepted; payload 00 00 with CMD_CHK=1 -> dropped.
REQ-033 ARP broadcast, oper 1, smac 02:03:04:05:04:05, sip C0A80105, tip C0A80104 -> o_arp_req once, outputs match; tip C0A80199 -> drop count +1.
REQ-034 Macro on: checksum D68E -> dropped; checksum 3871 -> accepted.
REQ-035 i_rst asserted at byte 20 of a valid command frame, released mid-frame -> no pulse, counter 0; next valid frame after 1-cycle gap accepted.
REQ-036 Two valid frames with 1-cycle gap -> two pulses, second values; 2047-byte frame -> drop; 0xFFFF drops -> counter holds.
